// File: rtl/zorro_arbiter.sv
// ----------------------------------------------------------------------------
// zorro_arbiter
//   Bus arbiter for a Zorro-style expansion bus. It collects requests from
//   SLOTS expansion slots plus one coprocessor, requests the bus from the CPU,
//   passes the CPU grant on to a single winner and tracks it until the new
//   master releases BGACKn. A grant that is never acknowledged is withdrawn
//   after TIMEOUT cycles.
//
//   Parameters
//     SLOTS    number of expansion slots (2..8)
//     RR_MODE  0 = fixed priority (slot 1 highest), 1 = round-robin
//     TIMEOUT  cycles a grant may wait for BGACKn; 0 disables the timeout
//
//   Ports (all active-low unless noted)
//     C7M      clock, rising edge
//     RESETn   asynchronous reset
//     BR       per-slot bus requests, bit 0 = slot 1
//     CBRn     coprocessor bus request (beats every slot)
//     BGn      CPU bus grant
//     BGACKn   bus-grant-acknowledge from the new master
//     BRn      registered bus request to the CPU
//     BG       registered per-slot grants
//     CBGn     registered coprocessor grant
//     OWNER    registered owner code (active-high): 0 none, 1..SLOTS slot,
//              SLOTS+1 coprocessor
//     TOUTn    one-cycle pulse when a grant times out
// ----------------------------------------------------------------------------
module zorro_arbiter #(
  parameter int SLOTS   = 5,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                       C7M,
  input  logic                       RESETn,
  input  logic [SLOTS-1:0]           BR,
  input  logic                       CBRn,
  input  logic                       BGn,
  input  logic                       BGACKn,
  output logic                       BRn,
  output logic [SLOTS-1:0]           BG,
  output logic                       CBGn,
  output logic [$clog2(SLOTS+2)-1:0] OWNER,
  output logic                       TOUTn
);

  localparam int OW = $clog2(SLOTS + 2);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OW-1:0] NONE      = '0;
  localparam logic [OW-1:0] SLOT1     = OW'(1);
  localparam logic [OW-1:0] LAST_SLOT = OW'(SLOTS);
  localparam logic [OW-1:0] COPRO     = OW'(SLOTS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    OWN
  } state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q,   ptr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             brn_q,   brn_d;
  logic [SLOTS-1:0] bg_q,    bg_d;
  logic             cbgn_q,  cbgn_d;
  logic             toutn_q, toutn_d;

  logic [SLOTS-1:0] slot_req;
  logic [OW-1:0]    search_start;
  logic [OW-1:0]    winner;
  logic             any_req;
  logic             owner_req;
  logic [OW-1:0]    ptr_next;
  logic [SLOTS-1:0] owner_grant;

  assign slot_req = ~BR;

  // Winner search. Fixed priority is a round-robin search that always starts
  // at slot 1: the first pass covers slots at or above the start point, the
  // second pass wraps around to the slots below it.
  always_comb begin
    search_start = (RR_MODE != 0) ? ptr_q : SLOT1;
    winner       = NONE;
    any_req      = 1'b0;
    if (!CBRn) begin
      winner  = COPRO;
      any_req = 1'b1;
    end
    for (int unsigned j = 0; j < SLOTS; j++) begin
      if (!any_req && slot_req[j] && (OW'(j + 1) >= search_start)) begin
        winner  = OW'(j + 1);
        any_req = 1'b1;
      end
    end
    for (int unsigned j = 0; j < SLOTS; j++) begin
      if (!any_req && slot_req[j]) begin
        winner  = OW'(j + 1);
        any_req = 1'b1;
      end
    end
  end

  // Is the latched owner still requesting, and which BG bit belongs to it.
  always_comb begin
    owner_req   = 1'b0;
    owner_grant = '1;
    if (owner_q == COPRO) begin
      owner_req = !CBRn;
    end
    for (int unsigned j = 0; j < SLOTS; j++) begin
      if (owner_q == OW'(j + 1)) begin
        owner_req      = slot_req[j];
        owner_grant[j] = 1'b0;
      end
    end
  end

  // Pointer moves one past the slot just served; coprocessor tenures leave
  // the rotation untouched.
  always_comb begin
    ptr_next = ptr_q;
    if ((RR_MODE != 0) && (owner_q != COPRO) && (owner_q != NONE)) begin
      ptr_next = (owner_q == LAST_SLOT) ? SLOT1 : (owner_q + SLOT1);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    brn_d   = brn_q;
    bg_d    = bg_q;
    cbgn_d  = cbgn_q;
    toutn_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          brn_d   = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        if (!owner_req) begin
          brn_d   = 1'b1;
          owner_d = NONE;
          state_d = IDLE;
        end else if (!BGn) begin
          if (owner_q == COPRO) begin
            cbgn_d = 1'b0;
          end else begin
            bg_d = owner_grant;
          end
          state_d = GRANT;
        end
      end

      GRANT: begin
        // Acknowledge is tested first so a late BGACKn in the final
        // timeout cycle still wins over the timeout.
        if (!BGACKn) begin
          bg_d    = '1;
          cbgn_d  = 1'b1;
          brn_d   = 1'b1;
          state_d = OWN;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          bg_d    = '1;
          cbgn_d  = 1'b1;
          brn_d   = 1'b1;
          toutn_d = 1'b0;
          owner_d = NONE;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : (cnt_q + 1'b1);
        end
      end

      OWN: begin
        if (BGACKn) begin
          owner_d = NONE;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = NONE;
        brn_d   = 1'b1;
        bg_d    = '1;
        cbgn_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge C7M or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      owner_q <= NONE;
      ptr_q   <= SLOT1;
      cnt_q   <= '0;
      brn_q   <= 1'b1;
      bg_q    <= '1;
      cbgn_q  <= 1'b1;
      toutn_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      brn_q   <= brn_d;
      bg_q    <= bg_d;
      cbgn_q  <= cbgn_d;
      toutn_q <= toutn_d;
    end
  end

  assign BRn   = brn_q;
  assign BG    = bg_q;
  assign CBGn  = cbgn_q;
  assign OWNER = owner_q;
  assign TOUTn = toutn_q;

endmodule

// File: doc/zorro_arbiter.md
ZORRO_ARBITER -- requirements
Module: zorro_arbiter

Interface
REQ-001 The module SHALL have a parameter SLOTS, default 5, giving the number of Zorro slots, legal range 2..8.
REQ-002 The module SHALL have a parameter RR_MODE, default 0: 0 selects fixed priority, 1 selects round-robin among slots.
REQ-003 The module SHALL have a parameter TIMEOUT, default 64: C7M cycles a grant may wait for BGACKn; 0 disables the timeout.
REQ-004 The module SHALL have port C7M, input, 1 bit: the only clock, all state updates on its rising edge.
REQ-005 The module SHALL have port RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port BR, input, SLOTS bits: active-low bus request per slot, bit 0 = slot 1.
REQ-007 The module SHALL have port CBRn, input, 1 bit: active-low coprocessor bus request.
REQ-008 The module SHALL have port BGn, input, 1 bit: active-low CPU bus grant.
REQ-009 The module SHALL have port BGACKn, input, 1 bit: active-low bus-grant-acknowledge from the new master.
REQ-010 The module SHALL have port BRn, output, 1 bit: active-low registered bus request to the CPU.
REQ-011 The module SHALL have port BG, output, SLOTS bits: active-low registered per-slot grants.
REQ-012 The module SHALL have port CBGn, output, 1 bit: active-low registered coprocessor grant.
REQ-013 The module SHALL have port OWNER, output, $clog2(SLOTS+2) bits: 0 = none, 1..SLOTS = slot, SLOTS+1 = coprocessor; the value is registered.
REQ-014 The module SHALL have port TOUTn, output, 1 bit: one-cycle active-low pulse on grant timeout.

Function
REQ-015 The module SHALL implement the states IDLE, REQ, GRANT and OWN.
REQ-016 Winner selection SHALL give the coprocessor (CBRn low) absolute priority over all slots.
REQ-017 With RR_MODE=0, among slots the lowest-numbered asserted request SHALL win.
REQ-018 With RR_MODE=1, the search SHALL start at pointer PTR and proceed upward with wrap from SLOTS back to slot 1; the first asserted request wins.
REQ-019 IDLE: on any request sampled, the winner SHALL be latched into OWNER, BRn driven low on the same edge, and the state SHALL move to REQ.
REQ-020 REQ: if BGn is sampled low and the latched winner's request is still asserted, the winner's BG bit (or CBGn) SHALL be driven low and the state SHALL move to GRANT.
REQ-021 REQ: if the winner withdraws its request before BGn is sampled low, BRn SHALL return high, OWNER SHALL clear to 0, and the state SHALL return to IDLE; another winner may be latched no earlier than the next cycle.
REQ-022 GRANT: on BGACKn sampled low, the grant and BRn SHALL go high and the state SHALL move to OWN; OWNER is held.
REQ-023 GRANT: the cycle counter SHALL count from 0; at count TIMEOUT-1 without BGACKn, the grant and BRn SHALL go high, TOUTn SHALL pulse low for one cycle, OWNER SHALL clear, and the state SHALL move to IDLE.
REQ-024 OWN: on BGACKn sampled high, the state SHALL move to IDLE and OWNER SHALL clear.
REQ-025 In RR_MODE=1, PTR SHALL be set to winner+1 (wrapping SLOTS to 1) on the OWN->IDLE or timeout exit; coprocessor wins SHALL leave PTR unchanged.
REQ-026 At most one of the BG bits and CBGn SHALL be low at any time.
REQ-027 Requests changing while the state is GRANT or OWN SHALL NOT change OWNER.
REQ-028 The counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL saturate, and SHALL clear on leaving GRANT.
REQ-029 A simultaneous BGACKn-low and timeout in the same cycle SHALL resolve as acknowledge, with no TOUTn pulse.

Reset
REQ-030 While RESETn is low, BRn, all BG bits, CBGn and TOUTn SHALL be 1, OWNER SHALL be 0, PTR SHALL be slot 1, the counter SHALL be 0 and the state SHALL be IDLE, all asynchronously, including mid-GRANT or mid-OWN.
REQ-031 The first request SHALL be sampled on the first C7M rising edge after RESETn deasserts.

Verification
REQ-032 BR=5'b11010 with RR_MODE=0, BGn low after 3 cycles, then BGACKn low -> BRn low, then BG=5'b11110, OWNER=1, then BG=5'b11111 and BRn high with state OWN.
REQ-033 CBRn low together with BR=5'b11110 -> CBGn low, OWNER=6, BG stays 5'b11111.
REQ-034 RR_MODE=1, slots 1 and 2 requesting continuously over four full grant cycles -> OWNER sequence 1,2,1,2.
REQ-035 TIMEOUT=4, grant issued and BGACKn held high -> grant released after 4 GRANT cycles, TOUTn low for exactly 1 cycle, OWNER=0.
REQ-036 RESETn pulsed low during OWN -> all grants and BRn high immediately, OWNER=0, and re-arbitration occurs after release.
